// File: rtl/hazard_pkg.sv
// Shared encodings and types for the pipeline hazard controller.
package hazard_pkg;

  // D-stage bypass select encodings
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  // E-stage bypass select encodings
  localparam logic [1:0] FWDE_PIPE = 2'd0;
  localparam logic [1:0] FWDE_M    = 2'd1;
  localparam logic [1:0] FWDE_W    = 2'd2;

  // M-stage store-data bypass select encodings
  localparam logic FWDM_PIPE = 1'b0;
  localparam logic FWDM_W    = 1'b1;

  // Tuse value meaning "operand not read" (all-ones at the default width)
  localparam int unsigned        TW_DEF    = 2;
  localparam logic [TW_DEF-1:0]  TUSE_NONE = '1;

  // Multiply/divide unit tracker states
  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_busy_tracker.sv
// Tracks multi-cycle mult/div occupancy so HI/LO consumers can be held in D.
module md_busy_tracker
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic md_start_i,
  input  logic md_is_div_i,
  output logic md_busy_o
);

  localparam int unsigned MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int unsigned CW      = $clog2(MAX_LAT + 1);

  md_state_e       state_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   lat_c;

  // Latency to load when an operation enters E
  assign lat_c = md_is_div_i ? CW'(DIV_LAT) : CW'(MULT_LAT);

  // FSM and latency counter; a new start always reloads the counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else if (md_start_i) begin
      state_q <= MD_BUSY;
      cnt_q   <= lat_c;
    end else if (state_q == MD_BUSY) begin
      if (cnt_q == CW'(1)) begin
        state_q <= MD_IDLE;
        cnt_q   <= '0;
      end else begin
        cnt_q   <= cnt_q - CW'(1);
      end
    end
  end

  assign md_busy_o = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: bypass selects, D-stage stall, stall counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned TW       = 2,
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] d_a1,
  input  logic [REG_AW-1:0] d_a2,
  input  logic [REG_AW-1:0] e_a1,
  input  logic [REG_AW-1:0] e_a2,
  input  logic [REG_AW-1:0] m_a2,
  input  logic [REG_AW-1:0] e_a3,
  input  logic [REG_AW-1:0] m_a3,
  input  logic [REG_AW-1:0] w_a3,
  input  logic              e_we,
  input  logic              m_we,
  input  logic              w_we,
  input  logic [TW-1:0]     tuse_rs,
  input  logic [TW-1:0]     tuse_rt,
  input  logic [TW-1:0]     tnew_e,
  input  logic [TW-1:0]     tnew_m,
  input  logic              e_md_start,
  input  logic              e_md_is_div,
  input  logic              d_md_use,
  output logic [1:0]        fwd_d_rs,
  output logic [1:0]        fwd_d_rt,
  output logic [1:0]        fwd_e_rs,
  output logic [1:0]        fwd_e_rt,
  output logic              fwd_m_rt,
  output logic              stall,
  output logic              pc_en,
  output logic              d_en,
  output logic              e_clr,
  output logic              md_busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  function automatic logic hit(input logic [REG_AW-1:0] a, input logic we,
                               input logic [REG_AW-1:0] dst);
    return (a != '0) && we && (dst == a);
  endfunction

  // Highest-priority producer decides; an ineligible one falls back to RF under stall
  function automatic logic [1:0] fwd_d(input logic he, input logic hm, input logic hw,
                                       input logic e_rdy, input logic m_rdy);
    logic [1:0] sel;
    sel = FWD_RF;
    if (he)      sel = e_rdy ? FWD_E : FWD_RF;
    else if (hm) sel = m_rdy ? FWD_M : FWD_RF;
    else if (hw) sel = FWD_W;
    return sel;
  endfunction

  logic e_rdy, m_rdy;
  logic d1_e, d1_m, d1_w, d2_e, d2_m, d2_w;
  logic e1_m, e1_w, e2_m, e2_w, m2_w;
  logic rs_stall, rt_stall, md_stall;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign e_rdy = (tnew_e == '0);
  assign m_rdy = (tnew_m == '0);

  // Register-address hit detection per consumer/producer pair
  always_comb begin
    d1_e = hit(d_a1, e_we, e_a3);
    d1_m = hit(d_a1, m_we, m_a3);
    d1_w = hit(d_a1, w_we, w_a3);
    d2_e = hit(d_a2, e_we, e_a3);
    d2_m = hit(d_a2, m_we, m_a3);
    d2_w = hit(d_a2, w_we, w_a3);
    e1_m = hit(e_a1, m_we, m_a3);
    e1_w = hit(e_a1, w_we, w_a3);
    e2_m = hit(e_a2, m_we, m_a3);
    e2_w = hit(e_a2, w_we, w_a3);
    m2_w = hit(m_a2, w_we, w_a3);
  end

  // Bypass selects for D, E and M consumers
  always_comb begin
    fwd_d_rs = fwd_d(d1_e, d1_m, d1_w, e_rdy, m_rdy);
    fwd_d_rt = fwd_d(d2_e, d2_m, d2_w, e_rdy, m_rdy);
    fwd_e_rs = FWDE_PIPE;
    if (e1_m && m_rdy) fwd_e_rs = FWDE_M;
    else if (e1_w)     fwd_e_rs = FWDE_W;
    fwd_e_rt = FWDE_PIPE;
    if (e2_m && m_rdy) fwd_e_rt = FWDE_M;
    else if (e2_w)     fwd_e_rt = FWDE_W;
    fwd_m_rt = m2_w ? FWDM_W : FWDM_PIPE;
  end

  // Tuse/Tnew data stall plus HI/LO occupancy stall
  always_comb begin
    rs_stall = !(&tuse_rs) && ((d1_e && (tnew_e > tuse_rs)) || (d1_m && (tnew_m > tuse_rs)));
    rt_stall = !(&tuse_rt) && ((d2_e && (tnew_e > tuse_rt)) || (d2_m && (tnew_m > tuse_rt)));
    md_stall = d_md_use && (e_md_start || md_busy);
    stall    = rs_stall || rt_stall || md_stall;
    pc_en    = !stall;
    d_en     = !stall;
    e_clr    = stall;
  end

  md_busy_tracker #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md (
    .clk         (clk),
    .rst_n       (rst_n),
    .md_start_i  (e_md_start),
    .md_is_div_i (e_md_is_div),
    .md_busy_o   (md_busy)
  );

  // Saturating stall-cycle counter next value
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Stall-cycle counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl (default build plus a 4-bit counter build).
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] d_a1, d_a2, e_a1, e_a2, m_a2, e_a3, m_a3, w_a3;
  logic       e_we, m_we, w_we;
  logic [1:0] tuse_rs, tuse_rt, tnew_e, tnew_m;
  logic       e_md_start, e_md_is_div, d_md_use;

  logic [1:0]  fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
  logic        fwd_m_rt, stall, pc_en, d_en, e_clr, md_busy;
  logic [31:0] stall_cnt;

  logic [1:0]  b_fwd_d_rs, b_fwd_d_rt, b_fwd_e_rs, b_fwd_e_rt;
  logic        b_fwd_m_rt, b_stall, b_pc_en, b_d_en, b_e_clr, b_md_busy;
  logic [3:0]  b_stall_cnt;

  int n_vec = 0;
  int n_err = 0;
  int exp_cnt;

  always #5 clk = ~clk;

  hazard_ctrl u_dut (
    .clk(clk), .rst_n(rst_n),
    .d_a1(d_a1), .d_a2(d_a2), .e_a1(e_a1), .e_a2(e_a2), .m_a2(m_a2),
    .e_a3(e_a3), .m_a3(m_a3), .w_a3(w_a3),
    .e_we(e_we), .m_we(m_we), .w_we(w_we),
    .tuse_rs(tuse_rs), .tuse_rt(tuse_rt), .tnew_e(tnew_e), .tnew_m(tnew_m),
    .e_md_start(e_md_start), .e_md_is_div(e_md_is_div), .d_md_use(d_md_use),
    .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt), .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt),
    .fwd_m_rt(fwd_m_rt), .stall(stall), .pc_en(pc_en), .d_en(d_en), .e_clr(e_clr),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .d_a1(d_a1), .d_a2(d_a2), .e_a1(e_a1), .e_a2(e_a2), .m_a2(m_a2),
    .e_a3(e_a3), .m_a3(m_a3), .w_a3(w_a3),
    .e_we(e_we), .m_we(m_we), .w_we(w_we),
    .tuse_rs(tuse_rs), .tuse_rt(tuse_rt), .tnew_e(tnew_e), .tnew_m(tnew_m),
    .e_md_start(e_md_start), .e_md_is_div(e_md_is_div), .d_md_use(d_md_use),
    .fwd_d_rs(b_fwd_d_rs), .fwd_d_rt(b_fwd_d_rt), .fwd_e_rs(b_fwd_e_rs), .fwd_e_rt(b_fwd_e_rt),
    .fwd_m_rt(b_fwd_m_rt), .stall(b_stall), .pc_en(b_pc_en), .d_en(b_d_en), .e_clr(b_e_clr),
    .md_busy(b_md_busy), .stall_cnt(b_stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    d_a1 = '0; d_a2 = '0; e_a1 = '0; e_a2 = '0; m_a2 = '0;
    e_a3 = '0; m_a3 = '0; w_a3 = '0;
    e_we = 1'b0; m_we = 1'b0; w_we = 1'b0;
    tuse_rs = TUSE_NONE; tuse_rt = TUSE_NONE; tnew_e = '0; tnew_m = '0;
    e_md_start = 1'b0; e_md_is_div = 1'b0; d_md_use = 1'b0;
  endtask

  // Start a mult/div with a HI/LO reader held in D; tally busy and stall cycles
  task automatic md_run(input logic is_div, input int lat, input string tag);
    int busy_n, stall_n, first_free;
    busy_n = 0; stall_n = 0; first_free = -1;
    step();
    clr();
    e_md_start = 1'b1; e_md_is_div = is_div; d_md_use = 1'b1;
    for (int i = 0; i < lat + 4; i++) begin
      #1;
      busy_n  += int'(md_busy);
      stall_n += int'(stall);
      if (!stall && first_free < 0) first_free = i;
      step();
      e_md_start = 1'b0; e_md_is_div = 1'b0;
    end
    exp_cnt += lat + 1;
    chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(lat));
    chk({tag, "_stall_cycles"}, 32'(stall_n), 32'(lat + 1));
    chk({tag, "_proceed_cycle"}, 32'(first_free), 32'(lat + 1));
    chk({tag, "_stall_cnt"}, stall_cnt, 32'(exp_cnt));
    clr();
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    exp_cnt = 0;
    #2;
    chk("rst_md_busy", 32'(md_busy), 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_pc_en", 32'(pc_en), 32'd1);
    chk("rst_e_clr", 32'(e_clr), 32'd0);
    #10;
    rst_n = 1'b1;

    // addu $3 in E, subu reads $3 in D: no stall, no D bypass yet
    step();
    clr();
    e_a3 = 5'd3; e_we = 1'b1; tnew_e = 2'd1; d_a1 = 5'd3; tuse_rs = 2'd1;
    #1;
    chk("alu_e_stall", 32'(stall), 32'd0);
    chk("alu_e_fwd_d_rs", 32'(fwd_d_rs), 32'd0);
    // Next cycle: addu in M ready, subu in E
    step();
    clr();
    m_a3 = 5'd3; m_we = 1'b1; tnew_m = 2'd0; e_a1 = 5'd3; d_a2 = 5'd3; tuse_rt = 2'd0;
    #1;
    chk("alu_m_fwd_e_rs", 32'(fwd_e_rs), 32'd1);
    chk("alu_m_fwd_d_rt", 32'(fwd_d_rt), 32'd2);
    chk("alu_m_stall", 32'(stall), 32'd0);

    // W-stage producer feeds every consumer
    step();
    clr();
    w_a3 = 5'd7; w_we = 1'b1; d_a1 = 5'd7; e_a2 = 5'd7; m_a2 = 5'd7;
    #1;
    chk("w_fwd_d_rs", 32'(fwd_d_rs), 32'd3);
    chk("w_fwd_e_rt", 32'(fwd_e_rt), 32'd2);
    chk("w_fwd_m_rt", 32'(fwd_m_rt), 32'd1);

    // E beats M and W when E result is ready
    step();
    clr();
    e_a3 = 5'd4; e_we = 1'b1; tnew_e = 2'd0;
    m_a3 = 5'd4; m_we = 1'b1; w_a3 = 5'd4; w_we = 1'b1; d_a2 = 5'd4; tuse_rt = 2'd0;
    #1;
    chk("prio_fwd_d_rt", 32'(fwd_d_rt), 32'd1);
    chk("prio_stall", 32'(stall), 32'd0);

    // lw $5 in E, beq reads $5 in D: two stall cycles
    step();
    clr();
    e_a3 = 5'd5; e_we = 1'b1; tnew_e = 2'd2; d_a1 = 5'd5; tuse_rs = 2'd0;
    #1;
    chk("lw_e_stall", 32'(stall), 32'd1);
    chk("lw_e_e_clr", 32'(e_clr), 32'd1);
    chk("lw_e_pc_en", 32'(pc_en), 32'd0);
    chk("lw_e_d_en", 32'(d_en), 32'd0);
    step();
    clr();
    m_a3 = 5'd5; m_we = 1'b1; tnew_m = 2'd1; d_a1 = 5'd5; tuse_rs = 2'd0;
    #1;
    chk("lw_m_stall", 32'(stall), 32'd1);
    chk("lw_m_fwd_d_rs", 32'(fwd_d_rs), 32'd0);
    step();
    clr();
    w_a3 = 5'd5; w_we = 1'b1; d_a1 = 5'd5; tuse_rs = 2'd0;
    #1;
    exp_cnt = 2;
    chk("lw_w_stall", 32'(stall), 32'd0);
    chk("lw_w_fwd_d_rs", 32'(fwd_d_rs), 32'd3);
    chk("lw_stall_cnt", stall_cnt, 32'(exp_cnt));

    // Writes to $0 never forward or stall
    step();
    clr();
    e_a3 = '0; m_a3 = '0; w_a3 = '0; e_we = 1'b1; m_we = 1'b1; w_we = 1'b1;
    tnew_e = 2'd2; tnew_m = 2'd1; tuse_rs = 2'd0; tuse_rt = 2'd0;
    #1;
    chk("r0_fwd_d_rs", 32'(fwd_d_rs), 32'd0);
    chk("r0_fwd_d_rt", 32'(fwd_d_rt), 32'd0);
    chk("r0_fwd_e_rs", 32'(fwd_e_rs), 32'd0);
    chk("r0_fwd_e_rt", 32'(fwd_e_rt), 32'd0);
    chk("r0_fwd_m_rt", 32'(fwd_m_rt), 32'd0);
    chk("r0_stall", 32'(stall), 32'd0);

    // rt stall rule and the "not used" Tuse
    step();
    clr();
    e_a3 = 5'd6; e_we = 1'b1; tnew_e = 2'd2; d_a2 = 5'd6; tuse_rt = TUSE_NONE;
    #1;
    chk("rt_none_stall", 32'(stall), 32'd0);
    tuse_rt = 2'd1;
    #1;
    chk("rt_tuse1_stall", 32'(stall), 32'd1);
    tuse_rt = 2'd2;
    #1;
    chk("rt_tuse2_stall", 32'(stall), 32'd0);
    clr();

    md_run(1'b1, 10, "div");
    md_run(1'b0, 5, "mult");

    // Reset during the third BUSY cycle of a div
    step();
    clr();
    e_md_start = 1'b1; e_md_is_div = 1'b1; d_md_use = 1'b1;
    step();
    e_md_start = 1'b0; e_md_is_div = 1'b0;
    step();
    step();
    #1;
    chk("abort_pre_busy", 32'(md_busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    chk("abort_md_busy", 32'(md_busy), 32'd0);
    chk("abort_stall_cnt", stall_cnt, 32'd0);
    chk("abort_stall", 32'(stall), 32'd0);
    #2;
    rst_n = 1'b1;
    step();
    #1;
    chk("abort_mflo_stall", 32'(stall), 32'd0);
    chk("abort_mflo_busy", 32'(md_busy), 32'd0);

    // 20 continuous stall cycles: 4-bit counter saturates at 15
    step();
    clr();
    e_a3 = 5'd5; e_we = 1'b1; tnew_e = 2'd2; d_a1 = 5'd5; tuse_rs = 2'd0;
    repeat (14) step();
    chk("sat_cnt4_14", 32'(b_stall_cnt), 32'd14);
    repeat (6) step();
    chk("sat_cnt4_hold", 32'(b_stall_cnt), 32'd15);
    chk("sat_cnt32_20", stall_cnt, 32'd20);
    clr();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard controller for the five-stage pipeline (F/D/E/M/W). It generates the bypass-mux selects and the D-stage stall from Tuse/Tnew analysis, and adds a multi-cycle multiply/divide busy tracker that stalls any D-stage MDU instruction until HI/LO is ready. It also maintains a saturating stall-cycle performance counter. It sits beside the datapath and drives the PC enable, the D-register enable, the E-register clear and all forward selects.

## Interface
Parameters:
- `REG_AW`, 5, register-address width.
- `TW`, 2, Tnew/Tuse width.
- `MULT_LAT`, 5, busy cycles for mult/multu (≥1).
- `DIV_LAT`, 10, busy cycles for div/divu (≥1).
- `CNT_W`, 32, stall counter width.

Ports:
- `clk` in 1, clock. One clock domain.
- `rst_n` in 1, asynchronous, active-low reset.
- `d_a1`, `d_a2` in REG_AW, D-stage rs/rt.
- `e_a1`, `e_a2` in REG_AW, E-stage rs/rt.
- `m_a2` in REG_AW, M-stage rt (store data).
- `e_a3`, `m_a3`, `w_a3` in REG_AW, destination per stage.
- `e_we`, `m_we`, `w_we` in 1, register write enable per stage.
- `tuse_rs`, `tuse_rt` in TW, D-stage use time. All-ones means "not used".
- `tnew_e`, `tnew_m` in TW, cycles until the result is ready.
- `e_md_start` in 1, mult/div in E this cycle.
- `e_md_is_div` in 1, qualifies `e_md_start`.
- `d_md_use` in 1, D instruction touches HI/LO (mult/div/mfhi/mflo/mthi/mtlo).
- `fwd_d_rs`, `fwd_d_rt` out 2: 0 = RF, 1 = E, 2 = M, 3 = W.
- `fwd_e_rs`, `fwd_e_rt` out 2: 0 = pipe reg, 1 = M, 2 = W.
- `fwd_m_rt` out 1: 0 = pipe reg, 1 = W.
- `stall` out 1, combined stall.
- `pc_en`, `d_en` out 1, equal to ~stall.
- `e_clr` out 1, equal to stall (inserts a bubble).
- `md_busy` out 1, MDU busy.
- `stall_cnt` out CNT_W, count of stalled cycles.

## Operation
- A hit on a register address requires that address ≠ 0, the stage's write enable is set, and the stage's destination equals the address.
- D forward priority is E > M > W. The E source is eligible only when tnew_e == 0; the M source only when tnew_m == 0; W is always eligible. If the highest-priority hit is not eligible, the select is 0, because a stall covers that case.
- E forward priority is M (tnew_m == 0) > W. The M-stage rt forward uses W only.
- Data stall (rs): a hit on E with tnew_e > tuse_rs, or a hit on M with tnew_m > tuse_rs. The rt rule is the same with tuse_rt. A tuse of all-ones never stalls.
- MDU FSM states:
  - IDLE → BUSY on e_md_start. The counter loads DIV_LAT when e_md_is_div is set, otherwise MULT_LAT.
  - BUSY decrements the counter each cycle and returns to IDLE in the cycle the counter is 1.
  - e_md_start while in BUSY reloads the counter. This is defined behaviour but illegal for correct pipeline control.
- md_busy = (state == BUSY).
- MDU stall = d_md_use & (e_md_start | md_busy).
- stall = data stall | MDU stall.
- stall_cnt increments on each clk edge where stall is 1 and saturates at all-ones.

## Timing
- Forward selects and stall/pc_en/d_en/e_clr are purely combinational from the current inputs and state. No added latency.
- MDU: if e_md_start is set at edge N, md_busy is high from N+1 through N+LAT inclusive. A D-stage MDU instruction is stalled in cycles N … N+LAT and proceeds in cycle N+LAT+1.
- Reset: state IDLE, counter 0, md_busy 0, stall_cnt 0, all applied immediately (asynchronously).
  - After reset, outputs depend only on the comb inputs.
  - Reset mid-BUSY aborts the tracking; no stall remains pending.
- Simultaneous stall sources simply OR together and count as one stall cycle.

## Structure
- Shared package `hazard_pkg`:
  - forward-select encodings (FWD_RF/FWD_E/FWD_M/FWD_W);
  - TUSE_NONE;
  - MDU FSM state typedef.
- One sub-module, `md_busy_tracker`, containing the FSM, the latency counter and md_busy.
- Forward/stall logic and stall_cnt live at the top level.

## Test plan
- addu $3 then subu using $3 in D (E hit, tnew_e = 1, tuse_rs = 1) → stall = 0, fwd_d_rs = 0. Next cycle, M hit with tnew_m = 0 → fwd_e_rs = 1.
- lw $5 in E (tnew_e = 2) with beq using $5 in D (tuse_rs = 0) → stall = 1, e_clr = 1, pc_en = 0 for 2 cycles, stall_cnt += 2.
- Writes to $0 in E, M and W with D reading $0 → all forward selects 0, stall = 0.
- div in E (e_md_start = 1, e_md_is_div = 1), mflo following in D → md_busy high for exactly 10 cycles, stall for 11 cycles. A mult instead gives 5 and 6.
- rst_n pulsed low in cycle 3 of a div's BUSY → md_busy = 0 and stall_cnt = 0 immediately. A subsequent mflo is not stalled.
- CNT_W = 4 with 20 continuous stall cycles → stall_cnt holds at 15.
